// File: rtl/fpro_cmd_master.sv
// Byte-stream command master: decodes 'W'/'R' frames from a UART byte stream into single
// FPro MMIO transactions and streams back 'K', read data, or '?'. Optional macro: FPRO_CMD_TIMEOUT_EN.
module fpro_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mmio_cs,
    output logic        mmio_wr,
    output logic        mmio_rd,
    output logic [20:0] mmio_addr,
    output logic [31:0] mmio_wr_data,
    input  logic [31:0] mmio_rd_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_RESP, S_ERR
    } state_t;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_wr;
    logic [1:0]  r_cnt;
    logic [20:0] r_addr;
    logic [31:0] r_wr_data;
    logic [31:0] r_resp;
    logic [1:0]  r_tx_idx;
    logic [1:0]  r_tx_last;
    logic        w_rx_fire;
    logic        w_tx_fire;
    logic        w_timeout;

    assign w_rx_fire = rx_valid && rx_ready;
    assign w_tx_fire = tx_valid && tx_ready;

`ifdef FPRO_CMD_TIMEOUT_EN
    logic [31:0] r_tmo;

    // Inter-byte watchdog: held at zero outside ADDR/DATA, so every entry starts fresh.
    always_ff @(posedge clk) begin
        if (reset)
            r_tmo <= '0;
        else if ((r_state != S_ADDR && r_state != S_DATA) || w_rx_fire)
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + 32'd1;
    end

    assign w_timeout = (r_state == S_ADDR || r_state == S_DATA) && !w_rx_fire
                       && (r_tmo == TIMEOUT_CYCLES - 1);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign w_timeout    = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_rx_fire)
                        w_next = (rx_data == OP_WR || rx_data == OP_RD) ? S_ADDR : S_ERR;
            S_ADDR: if (w_rx_fire && r_cnt == 2'd2)
                        w_next = r_is_wr ? S_DATA : S_BUS_RD;
                    else if (w_timeout)
                        w_next = S_IDLE;
            S_DATA: if (w_rx_fire && r_cnt == 2'd3)
                        w_next = S_BUS_WR;
                    else if (w_timeout)
                        w_next = S_IDLE;
            S_BUS_WR,
            S_BUS_RD: w_next = S_RESP;
            S_RESP: if (w_tx_fire && r_tx_idx == r_tx_last)
                        w_next = S_IDLE;
            S_ERR:  if (w_tx_fire)
                        w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        mmio_cs  = 1'b0;
        mmio_wr  = 1'b0;
        mmio_rd  = 1'b0;
        busy     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE, S_ADDR, S_DATA: rx_ready = 1'b1;
            S_BUS_WR: begin
                mmio_cs = 1'b1;
                mmio_wr = 1'b1;
            end
            S_BUS_RD: begin
                mmio_cs = 1'b1;
                mmio_rd = 1'b1;
            end
            S_RESP: begin
                tx_valid = 1'b1;
                tx_data  = r_resp[31:24];
            end
            S_ERR: begin
                tx_valid = 1'b1;
                tx_data  = RSP_ERR;
            end
            default: ;
        endcase
    end

    // Frame assembly and response buffer; the buffer shifts left one byte per tx handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_wr   <= 1'b0;
            r_cnt     <= 2'd0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_resp    <= '0;
            r_tx_idx  <= 2'd0;
            r_tx_last <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_rx_fire) begin
                    r_is_wr <= (rx_data == OP_WR);
                    r_cnt   <= 2'd0;
                end
                S_ADDR: if (w_rx_fire) begin
                    r_addr <= {r_addr[12:0], rx_data};
                    r_cnt  <= (r_cnt == 2'd2) ? 2'd0 : r_cnt + 2'd1;
                end
                S_DATA: if (w_rx_fire) begin
                    r_wr_data <= {r_wr_data[23:0], rx_data};
                    r_cnt     <= r_cnt + 2'd1;
                end
                S_BUS_WR: begin
                    r_resp    <= {RSP_ACK, 24'h0};
                    r_tx_idx  <= 2'd0;
                    r_tx_last <= 2'd0;
                end
                S_BUS_RD: begin
                    r_resp    <= mmio_rd_data;
                    r_tx_idx  <= 2'd0;
                    r_tx_last <= 2'd3;
                end
                S_RESP: if (w_tx_fire) begin
                    r_resp   <= {r_resp[23:0], 8'h00};
                    r_tx_idx <= r_tx_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign mmio_addr    = r_addr;
    assign mmio_wr_data = r_wr_data;

endmodule

// File: tb/tb_fpro_cmd_master.sv
// Directed bench for fpro_cmd_master: table-driven frames plus hand-written back-pressure,
// mid-frame reset and inter-byte timeout sequences.
module tb_fpro_cmd_master;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mmio_cs;
    logic        mmio_wr;
    logic        mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    fpro_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  rxd;
        logic        rxv;
        logic        txr;
        logic [31:0] rdd;
        logic [13:0] exp_ctl;
        logic        chk_bus;
        logic [20:0] exp_addr;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // {rx_ready, tx_valid, tx_data, cs, wr, rd, busy}
    function automatic logic [13:0] o_ctl(input logic rr, input logic txv, input logic [7:0] txd,
                                          input logic cs, input logic wr, input logic rd,
                                          input logic bsy);
        return {rr, txv, txd, cs, wr, rd, bsy};
    endfunction

    // tx_data only carries meaning while tx_valid is high
    function automatic logic [13:0] got_ctl();
        return {rx_ready, tx_valid, (tx_valid ? tx_data : 8'h00), mmio_cs, mmio_wr, mmio_rd, busy};
    endfunction

    function automatic logic [13:0] e_resp(input logic [7:0] b);
        return o_ctl(1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    task automatic add(input logic [7:0] d, input logic v, input logic [31:0] rdd,
                       input logic [13:0] e, input logic cb, input logic [20:0] a,
                       input logic [31:0] w);
        vec_t t;
        t.rxd = d; t.rxv = v; t.txr = 1'b1; t.rdd = rdd;
        t.exp_ctl = e; t.chk_bus = cb; t.exp_addr = a; t.exp_wd = w;
        vq.push_back(t);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
    endtask

    logic [13:0] e_idle, e_rx, e_bwr, e_brd, e_err;
    logic [7:0]  bp_bytes [4];
    int          delivered;
    int          strobes;
    int          txs;

    initial begin
        e_idle = o_ctl(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        e_rx   = o_ctl(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        e_bwr  = o_ctl(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
        e_brd  = o_ctl(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        e_err  = o_ctl(1'b0, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b1);

        // write 57 00 00 85 DE AD BE EF -> strobe, then 'K'
        add(8'h57, 1, 32'h12345678, e_idle, 0, 0, 0);
        add(8'h00, 1, 32'h12345678, e_rx,   0, 0, 0);
        add(8'h00, 1, 32'h12345678, e_rx,   0, 0, 0);
        add(8'h85, 1, 32'h12345678, e_rx,   0, 0, 0);
        add(8'hDE, 1, 32'h12345678, e_rx,   0, 0, 0);
        add(8'hAD, 1, 32'h12345678, e_rx,   0, 0, 0);
        add(8'hBE, 1, 32'h12345678, e_rx,   0, 0, 0);
        add(8'hEF, 1, 32'h12345678, e_rx,   0, 0, 0);
        add(8'h00, 0, 32'h12345678, e_bwr,  1, 21'h000085, 32'hDEADBEEF);
        add(8'h00, 0, 32'h12345678, e_resp(8'h4B), 1, 21'h000085, 32'hDEADBEEF);
        add(8'h00, 0, 32'h12345678, e_idle, 1, 21'h000085, 32'hDEADBEEF);
        // read 52 00 01 23 -> strobe, then 12 34 56 78
        add(8'h52, 1, 32'h12345678, e_idle, 0, 0, 0);
        add(8'h00, 1, 32'h12345678, e_rx,   0, 0, 0);
        add(8'h01, 1, 32'h12345678, e_rx,   0, 0, 0);
        add(8'h23, 1, 32'h12345678, e_rx,   0, 0, 0);
        add(8'h00, 0, 32'h12345678, e_brd,  1, 21'h000123, 32'hDEADBEEF);
        add(8'h00, 0, 32'h00000000, e_resp(8'h12), 0, 0, 0);
        add(8'h00, 0, 32'h00000000, e_resp(8'h34), 0, 0, 0);
        add(8'h00, 0, 32'h00000000, e_resp(8'h56), 0, 0, 0);
        add(8'h00, 0, 32'h00000000, e_resp(8'h78), 0, 0, 0);
        add(8'h00, 0, 32'h00000000, e_idle, 1, 21'h000123, 32'hDEADBEEF);
        // bad opcode -> '?', no strobe
        add(8'h41, 1, 32'h0, e_idle, 0, 0, 0);
        add(8'h00, 0, 32'h0, e_err,  0, 0, 0);
        add(8'h00, 0, 32'h0, e_idle, 0, 0, 0);
        // read with address bits 23:21 set, which must be dropped
        add(8'h52, 1, 32'hA5A50F0F, e_idle, 0, 0, 0);
        add(8'hE0, 1, 32'hA5A50F0F, e_rx,   0, 0, 0);
        add(8'h00, 1, 32'hA5A50F0F, e_rx,   0, 0, 0);
        add(8'h04, 1, 32'hA5A50F0F, e_rx,   0, 0, 0);
        add(8'h00, 0, 32'hA5A50F0F, e_brd,  1, 21'h000004, 32'hDEADBEEF);
        add(8'h00, 0, 32'h0, e_resp(8'hA5), 0, 0, 0);
        add(8'h00, 0, 32'h0, e_resp(8'hA5), 0, 0, 0);
        add(8'h00, 0, 32'h0, e_resp(8'h0F), 0, 0, 0);
        add(8'h00, 0, 32'h0, e_resp(8'h0F), 0, 0, 0);
        add(8'h00, 0, 32'h0, e_idle, 0, 0, 0);

        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1; mmio_rd_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_ctl", {rx_ready, tx_valid, tx_data, mmio_cs, mmio_wr, mmio_rd, busy},
              o_ctl(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        check("reset_bus", {mmio_addr, mmio_wr_data}, 53'h0);
        @(negedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            rx_data      = vq[i].rxd;
            rx_valid     = vq[i].rxv;
            tx_ready     = vq[i].txr;
            mmio_rd_data = vq[i].rdd;
            #1;
            check($sformatf("vec%0d_ctl", i), got_ctl(), vq[i].exp_ctl);
            if (vq[i].chk_bus)
                check($sformatf("vec%0d_bus", i), {mmio_addr, mmio_wr_data},
                      {vq[i].exp_addr, vq[i].exp_wd});
            @(negedge clk);
        end

        // back-pressure: 5 stalled cycles per response byte, 'R' queued meanwhile
        bp_bytes[0] = 8'hCA; bp_bytes[1] = 8'hFE; bp_bytes[2] = 8'hF0; bp_bytes[3] = 8'h0D;
        tx_ready = 1'b0;
        mmio_rd_data = 32'hCAFEF00D;
        send(8'h52); send(8'h00); send(8'h00); send(8'h10);
        rx_data = 8'h52;
        #1;
        check("bp_strobe", got_ctl(), e_brd);
        check("bp_addr", mmio_addr, 21'h000010);
        @(negedge clk);
        mmio_rd_data = '0;
        delivered = 0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 5; k++) begin
                tx_ready = 1'b0;
                #1;
                check($sformatf("bp_hold%0d_%0d", b, k), {tx_valid, tx_data, rx_ready},
                      {1'b1, bp_bytes[b], 1'b0});
                @(negedge clk);
            end
            tx_ready = 1'b1;
            #1;
            check($sformatf("bp_take%0d", b), {tx_valid, tx_data, rx_ready},
                  {1'b1, bp_bytes[b], 1'b0});
            if (tx_valid && tx_ready) delivered++;
            @(negedge clk);
        end
        #1;
        check("bp_idle", {rx_ready, busy, tx_valid}, 3'b100);
        if (tx_valid && tx_ready) delivered++;
        @(negedge clk);
        #1;
        check("bp_queued_accepted", {rx_ready, busy, tx_valid}, 3'b110);
        check("bp_delivered", delivered, 4);
        send(8'h00); send(8'h00); send(8'h00);
        rx_valid = 1'b0;
        mmio_rd_data = 32'h00000055;
        @(negedge clk);
        repeat (4) @(negedge clk);
        #1;
        check("bp_done", got_ctl(), e_idle);
        @(negedge clk);

        // reset after the 2nd address byte of a write
        send(8'h57); send(8'h00); send(8'h12);
        reset = 1'b1; rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_ctl", {rx_ready, tx_valid, tx_data, mmio_cs, mmio_wr, mmio_rd, busy},
              o_ctl(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        check("midrst_bus", {mmio_addr, mmio_wr_data}, 53'h0);
        strobes = 0; txs = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            if (mmio_cs) strobes++;
            if (tx_valid) txs++;
            @(negedge clk);
        end
        check("midrst_no_strobe", strobes, 0);
        check("midrst_no_tx", txs, 0);
        send(8'h57); send(8'h00); send(8'h00); send(8'h07);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        rx_valid = 1'b0;
        #1;
        check("postrst_strobe", got_ctl(), e_bwr);
        check("postrst_bus", {mmio_addr, mmio_wr_data}, {21'h000007, 32'h01020304});
        @(negedge clk);
        #1;
        check("postrst_ack", got_ctl(), e_resp(8'h4B));
        @(negedge clk);

`ifdef FPRO_CMD_TIMEOUT_EN
        // 57 00 then 16 silent cycles: frame abandoned
        send(8'h57); send(8'h00);
        rx_valid = 1'b0;
        strobes = 0;
        for (int k = 0; k < 15; k++) begin
            #1;
            if (mmio_cs || tx_valid) strobes++;
            @(negedge clk);
        end
        #1;
        check("tmo_waiting", {busy, rx_ready}, 2'b11);
        @(negedge clk);
        #1;
        check("tmo_idle", got_ctl(), e_idle);
        check("tmo_no_activity", strobes, 0);
        mmio_rd_data = 32'h11223344;
        send(8'h52); send(8'h00); send(8'h00); send(8'h09);
        rx_valid = 1'b0;
        #1;
        check("tmo_next_strobe", got_ctl(), e_brd);
        check("tmo_next_addr", mmio_addr, 21'h000009);
        @(negedge clk);
        #1;
        check("tmo_next_resp", got_ctl(), e_resp(8'h11));
        repeat (4) @(negedge clk);
`else
        // without the watchdog a stalled frame waits indefinitely and then completes
        send(8'h57); send(8'h00);
        rx_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("notmo_waiting", {busy, rx_ready}, 2'b11);
        @(negedge clk);
        send(8'h00); send(8'h05);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        rx_valid = 1'b0;
        #1;
        check("notmo_strobe", got_ctl(), e_bwr);
        check("notmo_bus", {mmio_addr, mmio_wr_data}, {21'h000005, 32'hAABBCCDD});
        @(negedge clk);
        #1;
        check("notmo_ack", got_ctl(), e_resp(8'h4B));
        @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
